hex_pixel_loader: RTL and testbench

Parametrised loader that turns a serial stream of ASCII-hex characters into packed pixel words and writes them into a frame buffer RAM. It sits between the UART receiver (byte + valid strobe) and the frame-buffer write port. It generalises the fixed 24-bit loader:

- pixel width and frame size are configurable;
- upper- and lower-case hex are both accepted, and whitespace is skipped;
- other characters are rejected and counted;
- a stalled partial pixel is discarded after a timeout;
- an explicit re-arm input aborts the current frame or starts the next one.

---
 rtl/hex_pixel_if.sv | 25 ++
 rtl/hex_pixel_loader.sv | 100 ++++++++++
 tb/tb_hex_pixel_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hex_pixel_if.sv
// hex_pixel_if: byte stream in, frame-buffer write port and status out
interface hex_pixel_if #(
  parameter int NIBBLES = 6,
  parameter int ADDR_W = 17
);
  localparam int PIX_W = 4 * NIBBLES;
  logic [7:0] rx_data;
  logic rx_vld;
  logic rearm;
  logic [PIX_W-1:0] pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic pix_we;
  logic frame_done;
  logic busy;
  logic [7:0] bad_char_cnt;
  logic [7:0] last_byte;
  modport master (
    output rx_data, rx_vld, rearm,
    input pix_data, pix_addr, pix_we, frame_done, busy, bad_char_cnt, last_byte
  );
  modport slave (
    input rx_data, rx_vld, rearm,
    output pix_data, pix_addr, pix_we, frame_done, busy, bad_char_cnt, last_byte
  );
endinterface

// File: rtl/hex_pixel_loader.sv
// hex_pixel_loader: assembles ASCII-hex bytes into pixels and writes them to a frame buffer
module hex_pixel_loader #(
  parameter int NIBBLES = 6,
  parameter int NUM_PIX = 129600,
  parameter int ADDR_W = 17,
  parameter int TIMEOUT_CYC = 0
) (
  input logic clk,
  input logic rst_n,
  hex_pixel_if.slave bus
);
  localparam int PIX_W = 4 * NIBBLES;
  localparam int NW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TLIM = TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0;
  typedef enum logic {COLLECT, DONE} state_t;
  state_t state;
  logic [PIX_W-1:0] acc, acc_nx, pix_data;
  logic [NW-1:0] nib_idx;
  logic [TW-1:0] tcnt;
  logic [ADDR_W-1:0] pix_addr, addr_inc, wr_addr;
  logic pix_we, frame_done;
  logic [7:0] bad_char_cnt, last_byte, d;
  logic is_dig, is_hex, is_ws, nib_last, wr_last, t_exp;
  logic [3:0] nv;
  always_comb begin
    d = bus.rx_data;
    is_dig = d >= "0" && d <= "9";
    is_hex = is_dig || (d >= "a" && d <= "f") || (d >= "A" && d <= "F");
    is_ws = d == 8'h20 || d == 8'h09 || d == 8'h0d || d == 8'h0a;
    nv = is_dig ? d[3:0] : d[3:0] + 4'd9;
    acc_nx = PIX_W'({acc, nv});
    nib_last = nib_idx == NW'(NIBBLES - 1);
    addr_inc = pix_addr == ADDR_W'(NUM_PIX - 1) ? '0 : pix_addr + ADDR_W'(1);
    // a pixel completing during the previous write targets the already-advanced address
    wr_addr = pix_we ? addr_inc : pix_addr;
    wr_last = wr_addr == ADDR_W'(NUM_PIX - 1);
    t_exp = tcnt == TW'(TLIM);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= COLLECT;
      acc <= '0;
      nib_idx <= '0;
      tcnt <= '0;
      pix_data <= '0;
      pix_addr <= '0;
      pix_we <= 1'b0;
      frame_done <= 1'b0;
      bad_char_cnt <= '0;
      last_byte <= '0;
    end else begin
      pix_we <= 1'b0;
      if (pix_we) pix_addr <= addr_inc;
      if (state == DONE) begin
        if (bus.rearm) begin
          state <= COLLECT;
          frame_done <= 1'b0;
          pix_addr <= '0;
        end
      end else if (bus.rearm) begin
        acc <= '0;
        nib_idx <= '0;
        tcnt <= '0;
        pix_addr <= '0;
      end else if (bus.rx_vld) begin
        tcnt <= '0;
        if (is_hex) begin
          acc <= acc_nx;
          nib_idx <= nib_last ? '0 : nib_idx + NW'(1);
          if (nib_idx[0]) last_byte <= {acc[3:0], nv};
          if (nib_last) begin
            pix_data <= acc_nx;
            pix_we <= 1'b1;
          end
          if (nib_last && wr_last) begin
            frame_done <= 1'b1;
            state <= DONE;
          end
        end else if (!is_ws) begin
          acc <= '0;
          nib_idx <= '0;
          bad_char_cnt <= bad_char_cnt + (bad_char_cnt != 8'hff ? 8'd1 : 8'd0);
        end
      end else if (TIMEOUT_CYC > 0 && nib_idx != '0) begin
        tcnt <= t_exp ? '0 : tcnt + TW'(1);
        if (t_exp) begin
          acc <= '0;
          nib_idx <= '0;
        end
      end
    end
  assign bus.pix_data = pix_data;
  assign bus.pix_addr = pix_addr;
  assign bus.pix_we = pix_we;
  assign bus.frame_done = frame_done;
  assign bus.busy = state == COLLECT && (nib_idx != '0 || pix_addr != '0);
  assign bus.bad_char_cnt = bad_char_cnt;
  assign bus.last_byte = last_byte;
endmodule

// File: tb/tb_hex_pixel_loader.sv
// tb_hex_pixel_loader: randomized and directed checks against a character-level reference model
module tb_hex_pixel_loader;
  localparam int NIB = 6;
  localparam int NPIX = 4;
  localparam int AW = 3;
  localparam int TO = 10;
  localparam int PW = 4 * NIB;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hex_pixel_if #(.NIBBLES(NIB), .ADDR_W(AW)) bus ();
  hex_pixel_loader #(.NIBBLES(NIB), .NUM_PIX(NPIX), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int n_chk = 0, n_err = 0, nwr = 0;
  logic [PW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  int m_nibs, m_idle, m_written, m_bad, m_wa;
  logic [PW-1:0] m_val, m_data;
  logic [7:0] m_last;
  bit m_done, m_we;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c == 8'h20 || c == 8'h09 || c == 8'h0d || c == 8'h0a) return -2;
    return -1;
  endfunction
  task automatic m_reset();
    m_nibs = 0; m_idle = 0; m_written = 0; m_bad = 0; m_wa = 0;
    m_val = '0; m_data = '0; m_last = '0; m_done = 0; m_we = 0;
  endtask
  // one clock edge of the reference behaviour, stated at character level
  task automatic m_edge(input bit v, input logic [7:0] d, input bit r);
    int h;
    m_we = 0;
    if (m_done) begin
      if (r) begin m_done = 0; m_written = 0; end
      return;
    end
    if (r) begin m_nibs = 0; m_val = '0; m_written = 0; m_idle = 0; return; end
    if (!v) begin
      if (m_nibs > 0) begin
        m_idle++;
        if (m_idle == TO) begin m_nibs = 0; m_idle = 0; m_val = '0; end
      end
      return;
    end
    m_idle = 0;
    h = hexval(d);
    if (h == -2) return;
    if (h == -1) begin
      m_nibs = 0; m_val = '0;
      if (m_bad < 255) m_bad++;
      return;
    end
    m_val = {m_val[PW-5:0], 4'(h)};
    m_nibs++;
    if (m_nibs % 2 == 0) m_last = m_val[7:0];
    if (m_nibs == NIB) begin
      m_data = m_val; m_we = 1; m_wa = m_written;
      m_nibs = 0; m_val = '0; m_written++;
      if (m_written == NPIX) begin m_done = 1; m_written = 0; end
    end
  endtask
  task automatic check_outputs();
    int ea;
    ea = m_we ? m_wa : m_written;
    chk("pix_we", 32'(bus.pix_we), 32'(m_we));
    chk("pix_addr", 32'(bus.pix_addr), 32'(ea));
    chk("pix_data", 32'(bus.pix_data), 32'(m_data));
    chk("frame_done", 32'(bus.frame_done), 32'(m_done));
    chk("busy", 32'(bus.busy), 32'(!m_done && (m_nibs != 0 || ea != 0)));
    chk("bad_cnt", 32'(bus.bad_char_cnt), 32'(m_bad));
    chk("last_byte", 32'(bus.last_byte), 32'(m_last));
  endtask
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    bus.rx_vld = v; bus.rx_data = d; bus.rearm = r;
    @(posedge clk);
    if (!rst_n) m_reset(); else m_edge(v, d, r);
    #1;
    check_outputs();
    if (bus.pix_we) begin nwr++; wr_data = bus.pix_data; wr_addr = bus.pix_addr; end
  endtask
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask
  initial begin
    int n0, r;
    logic [PW-1:0] v;
    string hx, ws, bad;
    hx = "0123456789abcdefABCDEF";
    ws = " \t\r\n";
    bad = "xyz#G!@g:";
    bus.rx_vld = 1'b0; bus.rx_data = 8'h00; bus.rearm = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    idle(2);
    send("ff"); chk("t1_lb_ff", 32'(bus.last_byte), 32'h0ff);
    send("00"); chk("t1_lb_00", 32'(bus.last_byte), 32'h000);
    send("AA"); chk("t1_lb_aa", 32'(bus.last_byte), 32'h0aa);
    chk("t1_nwr", 32'(nwr), 32'd1);
    chk("t1_data", 32'(wr_data), 32'hff00aa);
    chk("t1_addr", 32'(wr_addr), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    n0 = nwr;
    send("12 34\r\n56");
    chk("t2_nwr", 32'(nwr - n0), 32'd1);
    chk("t2_data", 32'(wr_data), 32'h123456);
    chk("t2_addr", 32'(wr_addr), 32'd0);
    chk("t2_bad", 32'(bus.bad_char_cnt), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    send("12g345678abc");
    chk("t3_bad", 32'(bus.bad_char_cnt), 32'd1);
    chk("t3_data", 32'(wr_data), 32'h345678);
    chk("t3_addr", 32'(wr_addr), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    n0 = nwr;
    send("abc");
    idle(10);
    send("112233");
    chk("t4_nwr", 32'(nwr - n0), 32'd1);
    chk("t4_data", 32'(wr_data), 32'h112233);
    chk("t4_addr", 32'(wr_addr), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    for (int p = 0; p < NPIX; p++) begin
      v = PW'($urandom);
      send(p[0] ? $sformatf("%06X", v) : $sformatf("%06x", v));
      chk("t5_addr", 32'(wr_addr), 32'(p));
      chk("t5_data", 32'(wr_data), 32'(v));
    end
    chk("t5_done", 32'(bus.frame_done), 32'd1);
    n0 = nwr;
    send("aaaaaa");
    chk("t5_drop", 32'(nwr - n0), 32'd0);
    chk("t5_done_hold", 32'(bus.frame_done), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_rearm", 32'(bus.frame_done), 32'd0);
    send("0a0B0c");
    chk("t5_re_addr", 32'(wr_addr), 32'd0);
    chk("t5_re_data", 32'(wr_data), 32'h0a0b0c);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) step(1'b0, 8'h00, 1'b1);
      else if (r < 4) step(1'b1, hx[$urandom_range(0, 21)], 1'b1);
      else if (r < 12) idle($urandom_range(1, 13));
      else if (r < 20) step(1'b1, ws[$urandom_range(0, 3)], 1'b0);
      else if (r < 24) step(1'b1, bad[$urandom_range(0, 8)], 1'b0);
      else step(1'b1, hx[$urandom_range(0, 21)], 1'b0);
    end
    step(1'b0, 8'h00, 1'b1);
    repeat (300) step(1'b1, "#", 1'b0);
    chk("t6_sat", 32'(bus.bad_char_cnt), 32'd255);
    send("123");
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    chk("t6_rst_data", 32'(bus.pix_data), 32'd0);
    chk("t6_rst_addr", 32'(bus.pix_addr), 32'd0);
    chk("t6_rst_we", 32'(bus.pix_we), 32'd0);
    chk("t6_rst_done", 32'(bus.frame_done), 32'd0);
    chk("t6_rst_bad", 32'(bus.bad_char_cnt), 32'd0);
    chk("t6_rst_lb", 32'(bus.last_byte), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    n0 = nwr;
    send("456");
    rst_n = 1'b1;
    idle(2);
    chk("t6_no_write", 32'(nwr - n0), 32'd0);
    send("abcdef");
    chk("t6_post_data", 32'(wr_data), 32'habcdef);
    chk("t6_post_addr", 32'(wr_addr), 32'd0);
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
